// File: rtl/tri_lane_dispatch.sv
// One-entry triangle buffer that hands bounding-boxed triangles to the
// first idle sample-test iterator lane (round-robin) and tags them in order.
module tri_lane_dispatch #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int LANES  = 2,
    parameter int TAGW   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]           color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]             box_R13S,
    input  logic                                    validTri_R13H,
    output logic                                    halt_RnnnnL,
    input  logic [LANES-1:0]                        laneReady_H,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_D13S,
    output logic [COLORS-1:0][SIGFIG-1:0]           color_D13U,
    output logic [1:0][1:0][SIGFIG-1:0]             box_D13S,
    output logic [TAGW-1:0]                         tag_D13U,
    output logic [LANES-1:0]                        laneValid_H,
    output logic [15:0]                             dropCnt_U,
    output logic [31:0]                             dispCnt_U
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;
    localparam int         RW       = $clog2(LANES);

    if (LANES < 2 || LANES > 8 || RADIX >= SIGFIG) begin : g_bad_param
        $error("tri_lane_dispatch: unsupported parameters");
    end

    logic [0:0]                             state_q, state_d;
    logic [RW-1:0]                          rr_q, rr_d;
    logic [TAGW-1:0]                        seq_q, seq_d;
    logic [TAGW-1:0]                        tag_q, tag_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
    logic [1:0][1:0][SIGFIG-1:0]            box_q, box_d;
    logic [15:0]                            drop_q, drop_d;
    logic [31:0]                            disp_q, disp_d;
    logic                                   loaded_q, loaded_d;

    logic [LANES-1:0] grant;
    logic [RW-1:0]    gidx;
    logic             found;
    int               j;
    logic             full, xfer, accept, degen, load, drop;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < LANES; k++) begin
            j = (int'(rr_q) + k) % LANES;
            if (!found && laneReady_H[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                gidx     = RW'(j);
            end
        end
    end

    assign full        = (state_q == ST_FULL);
    assign xfer        = full && found;
    assign laneValid_H = full ? grant : '0;
    assign halt_RnnnnL = !full || xfer;

    assign degen  = ($signed(box_R13S[0][0]) > $signed(box_R13S[1][0]))
                 || ($signed(box_R13S[0][1]) > $signed(box_R13S[1][1]));
    assign accept = validTri_R13H && halt_RnnnnL;
    assign load   = accept && !degen;
    assign drop   = accept && degen;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        seq_d    = seq_q;
        tag_d    = tag_q;
        tri_d    = tri_q;
        color_d  = color_q;
        box_d    = box_q;
        drop_d   = drop_q;
        disp_d   = disp_q;
        loaded_d = loaded_q;
        if (xfer) begin
            disp_d = disp_q + 32'd1;
            rr_d   = RW'((int'(gidx) + 1) % LANES);
        end
        if (drop && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
        // Load wins over drain so back-to-back triangles never bubble.
        if (load) begin
            tri_d    = tri_R13S;
            color_d  = color_R13U;
            box_d    = box_R13S;
            tag_d    = seq_q;
            seq_d    = seq_q + 1'b1;
            loaded_d = 1'b1;
            state_d  = ST_FULL;
        end else if (xfer) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_EMPTY;
            rr_q     <= '0;
            seq_q    <= '0;
            tag_q    <= '0;
            tri_q    <= '0;
            color_q  <= '0;
            box_q    <= '0;
            drop_q   <= '0;
            disp_q   <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            seq_q    <= seq_d;
            tag_q    <= tag_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            box_q    <= box_d;
            drop_q   <= drop_d;
            disp_q   <= disp_d;
            loaded_q <= loaded_d;
        end
    end

    assign tri_D13S   = tri_q;
    assign color_D13U = color_q;
    assign box_D13S   = box_q;
    assign tag_D13U   = tag_q;
    assign dropCnt_U  = drop_q;
    assign dispCnt_U  = disp_q;

    a_onehot : assert property (@(posedge clk) disable iff (!rst)
        $onehot0(laneValid_H));
    a_ready : assert property (@(posedge clk) disable iff (!rst)
        (laneValid_H & ~laneReady_H) == '0);
    a_noload : assert property (@(posedge clk) disable iff (!rst)
        !(full && !xfer && load));
    // tag_q always holds the previous load's tag once anything was loaded.
    a_tagseq : assert property (@(posedge clk) disable iff (!rst)
        (load && loaded_q) |-> (seq_q == tag_q + 1'b1));

endmodule
